// File: rtl/instruction_encoder_loader.sv
// Packs MIPS R/I/J fields into 32-bit words and writes them to instruction memory in order.
// Handshake in cycle N gives a write request in N+1; a write is held stable until MemReady.
module instruction_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [1:0]            Format,
  input  logic [5:0]            Opcode,
  input  logic [4:0]            Rs,
  input  logic [4:0]            Rt,
  input  logic [4:0]            Rd,
  input  logic [4:0]            Shamt,
  input  logic [5:0]            Funct,
  input  logic [15:0]           Immediate,
  input  logic [25:0]           Address,
  input  logic                  Last,
  input  logic                  InValid,
  output logic                  InReady,
  output logic                  MemWriteEnable,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemWriteData,
  input  logic                  MemReady,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_WIDTH:0]   WordCount
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state;
  logic                last_q;
  logic [31:0]         enc;
  logic [ADDR_WIDTH:0] wc_inc;

  assign wc_inc = WordCount + 1'b1;

  // Same bit positions as the decoder, so an encoded word decodes to the same fields.
  always_comb begin
    enc = 32'h0;
    case (Format)
      2'b00:   enc = {Opcode, Rs, Rt, Rd, Shamt, Funct};
      2'b01:   enc = {Opcode, Rs, Rt, Immediate};
      2'b10:   enc = {Opcode, Address};
      default: enc = 32'h0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state          <= IDLE;
      last_q         <= 1'b0;
      InReady        <= 1'b0;
      MemWriteEnable <= 1'b0;
      MemAddress     <= '0;
      MemWriteData   <= 32'h0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Error          <= 1'b0;
      WordCount      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state     <= ACCEPT;
            InReady   <= 1'b1;
            Busy      <= 1'b1;
            WordCount <= '0;
            Error     <= 1'b0;
          end
        end
        ACCEPT: begin
          if (InValid) begin
            InReady <= 1'b0;
            if (Format == 2'b11) begin
              Error <= 1'b1;
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              MemWriteData   <= enc;
              MemAddress     <= BASE + WordCount[ADDR_WIDTH-1:0];
              last_q         <= Last;
              MemWriteEnable <= 1'b1;
              state          <= WRITE;
            end
          end
        end
        WRITE: begin
          if (MemReady) begin
            MemWriteEnable <= 1'b0;
            WordCount      <= wc_inc;
            // Overflow is judged on the count, not the wrapped address.
            if (last_q) begin
              Done  <= 1'b1;
              state <= DONE;
            end else if (wc_inc == FULL) begin
              Error <= 1'b1;
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              InReady <= 1'b1;
              state   <= ACCEPT;
            end
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Bench: directed and random load sessions against a field-packing reference model with a write scoreboard.
module tb_instruction_encoder_loader;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start, start2, invalid, invalid2, last, memready;
  logic [1:0]  fmt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;

  logic        inready, mwe, busy, done, err;
  logic [7:0]  maddr;
  logic [31:0] mdata;
  logic [8:0]  wcount;

  logic        inready2, mwe2, busy2, done2, err2;
  logic [1:0]  maddr2;
  logic [31:0] mdata2;
  logic [2:0]  wcount2;

  int  total = 0;
  int  bad = 0;
  int  mr_mode = 1;
  wr_t exp_q[$];
  wr_t q2[$];

  instruction_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .Clock(clk), .ResetN(rstn), .Start(start), .Format(fmt), .Opcode(opcode),
    .Rs(rs), .Rt(rt), .Rd(rd), .Shamt(shamt), .Funct(funct), .Immediate(imm),
    .Address(jaddr), .Last(last), .InValid(invalid), .InReady(inready),
    .MemWriteEnable(mwe), .MemAddress(maddr), .MemWriteData(mdata),
    .MemReady(memready), .Busy(busy), .Done(done), .Error(err), .WordCount(wcount)
  );

  instruction_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .Clock(clk), .ResetN(rstn), .Start(start2), .Format(fmt), .Opcode(opcode),
    .Rs(rs), .Rt(rt), .Rd(rd), .Shamt(shamt), .Funct(funct), .Immediate(imm),
    .Address(jaddr), .Last(last), .InValid(invalid2), .InReady(inready2),
    .MemWriteEnable(mwe2), .MemAddress(maddr2), .MemWriteData(mdata2),
    .MemReady(memready), .Busy(busy2), .Done(done2), .Error(err2), .WordCount(wcount2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference encoding straight from the MIPS field layout.
  function automatic logic [31:0] model_word(input logic [1:0] f);
    logic [31:0] w;
    w = 32'h0;
    if (f == 2'd0) w = {opcode, rs, rt, rd, shamt, funct};
    else if (f == 2'd1) w = {opcode, rs, rt, imm};
    else if (f == 2'd2) w = {opcode, jaddr};
    return w;
  endfunction

  // Memory-ready driver: 0 = stall, 1 = always ready, 2 = random.
  initial begin
    memready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (mr_mode == 0) memready = 1'b0;
      else if (mr_mode == 1) memready = 1'b1;
      else memready = 1'($urandom_range(0, 1));
    end
  end

  // Write monitor for the 8-bit-address instance.
  initial begin
    logic        hold, acc;
    logic [7:0]  ha;
    logic [31:0] hd;
    wr_t         e;
    hold = 1'b0;
    acc  = 1'b0;
    ha   = '0;
    hd   = '0;
    forever begin
      @(negedge clk);
      if (acc) chk("mwe_drop", 64'(mwe), 64'(0));
      acc = 1'b0;
      if (mwe && hold) begin
        chk("hold_addr", 64'(maddr), 64'(ha));
        chk("hold_data", 64'(mdata), 64'(hd));
      end
      hold = mwe && !memready;
      ha   = maddr;
      hd   = mdata;
      if (mwe && memready) begin
        acc = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h want no write", maddr, mdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(maddr), 64'(e.a));
          chk("wr_data", 64'(mdata), 64'(e.d));
        end
      end
    end
  end

  // Write monitor for the 2-bit-address instance.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mwe2 && memready) begin
        if (q2.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write2: got addr=%0h data=%0h want no write", maddr2, mdata2);
        end else begin
          e = q2.pop_front();
          chk("wr2_addr", 64'(maddr2), 64'(e.a[1:0]));
          chk("wr2_data", 64'(mdata2), 64'(e.d));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic rand_fields();
    opcode = 6'($urandom);
    rs     = 5'($urandom);
    rt     = 5'($urandom);
    rd     = 5'($urandom);
    shamt  = 5'($urandom);
    funct  = 6'($urandom);
    imm    = 16'($urandom);
    jaddr  = 26'($urandom);
  endtask

  task automatic set_r_add();
    rand_fields();
    fmt = 2'd0; opcode = 6'd0; rs = 5'd8; rt = 5'd9; rd = 5'd10; shamt = 5'd0; funct = 6'h20;
  endtask

  task automatic chk_zero();
    chk("rst_inready", 64'(inready), 64'(0));
    chk("rst_mwe", 64'(mwe), 64'(0));
    chk("rst_maddr", 64'(maddr), 64'(0));
    chk("rst_mdata", 64'(mdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_wcount", 64'(wcount), 64'(0));
    chk("rst_busy2", 64'(busy2), 64'(0));
  endtask

  // All tasks below start and end just after a falling edge.
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_err", 64'(err), 64'(0));
    chk("start_wcount", 64'(wcount), 64'(0));
    chk("start_ready", 64'(inready), 64'(1));
  endtask

  task automatic send1(input logic [31:0] w, input logic [7:0] a);
    bit ok;
    ok = 1'b0;
    invalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (inready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got inready=0 want 1");
      invalid = 1'b0;
    end else begin
      if (fmt != 2'b11) exp_q.push_back('{a: a, d: w});
      @(posedge clk);
      #1;
      invalid = 1'b0;
      if (fmt != 2'b11) chk("latency_mwe", 64'(mwe), 64'(1));
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int cnt, input bit e);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=0 want 1");
    end else begin
      chk("done_wcount", 64'(wcount), 64'(cnt));
      chk("done_err", 64'(err), 64'(e));
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
    end
  endtask

  task automatic session(input int n, input bit allow_illegal);
    int cnt;
    bit e;
    cnt = 0;
    e = 1'b0;
    start_pulse();
    for (int i = 0; i < n; i++) begin
      rand_fields();
      fmt = (allow_illegal && $urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      last = (i == n - 1);
      send1(model_word(fmt), 8'(cnt));
      if (fmt == 2'b11) begin
        e = 1'b1;
        break;
      end
      cnt++;
    end
    wait_done(cnt, e);
  endtask

  initial begin
    bit ok;
    rstn = 1'b0; start = 1'b0; start2 = 1'b0; invalid = 1'b0; invalid2 = 1'b0; last = 1'b0;
    fmt = 2'd0;
    rand_fields();
    repeat (2) @(negedge clk);
    chk_zero();
    rstn = 1'b1;
    @(negedge clk);

    // Single R-format word.
    mr_mode = 1;
    start_pulse();
    set_r_add(); last = 1'b1;
    send1(32'h01095020, 8'd0);
    wait_done(1, 1'b0);

    // I, J, R session.
    start_pulse();
    rand_fields(); fmt = 2'd1; opcode = 6'd8; rs = 5'd0; rt = 5'd8; imm = 16'd5; last = 1'b0;
    send1(32'h20080005, 8'd0);
    rand_fields(); fmt = 2'd2; opcode = 6'd2; jaddr = 26'h0100000;
    send1(32'h08100000, 8'd1);
    set_r_add(); last = 1'b1;
    send1(32'h01095020, 8'd2);
    wait_done(3, 1'b0);

    // Memory stalls four cycles.
    mr_mode = 0;
    start_pulse();
    set_r_add(); last = 1'b1;
    send1(32'h01095020, 8'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_mwe", 64'(mwe), 64'(1));
      @(negedge clk);
    end
    mr_mode = 1;
    wait_done(1, 1'b0);

    // Illegal format on the second bundle, then Error clears on the next Start.
    start_pulse();
    rand_fields(); fmt = 2'd1; last = 1'b0;
    send1(model_word(fmt), 8'd0);
    rand_fields(); fmt = 2'b11;
    send1(32'h0, 8'd1);
    wait_done(1, 1'b1);
    session(3, 1'b0);

    // Random sessions with random memory backpressure.
    mr_mode = 2;
    for (int s = 0; s < 25; s++) session(int'($urandom_range(1, 6)), 1'b1);

    // Reset during a stalled write; Start while busy is ignored.
    mr_mode = 0;
    repeat (2) @(negedge clk);
    start_pulse();
    set_r_add(); last = 1'b1;
    send1(32'h01095020, 8'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_mwe", 64'(mwe), 64'(1));
    chk("busy_start_wcount", 64'(wcount), 64'(0));
    chk("busy_start_maddr", 64'(maddr), 64'(0));
    rstn = 1'b0;
    @(negedge clk);
    chk_zero();
    exp_q.delete();
    rstn = 1'b1;
    mr_mode = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_mwe", 64'(mwe), 64'(0));
    chk("post_rst_ready", 64'(inready), 64'(0));

    // Small memory fills up after four words.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      fmt = 2'($urandom_range(0, 2));
      last = 1'b0;
      q2.push_back('{a: 8'(i), d: model_word(fmt)});
      invalid2 = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        if (inready2) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL handshake2_timeout: got inready=0 want 1");
      end
      @(posedge clk);
      #1;
      invalid2 = 1'b0;
      @(negedge clk);
    end
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (done2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done2_timeout: got done=0 want 1");
    end
    chk("full_err", 64'(err2), 64'(1));
    chk("full_wcount", 64'(wcount2), 64'(4));

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("queue2_empty", 64'(q2.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
